// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a first-word-fall-through FIFO of {pc, instr} pairs, cleared on redirect.
// Latency: an entry pushed at edge N is visible at the output after that edge (no same-cycle bypass when empty).
// Backpressure: in_ready = (count < DEPTH) from registered state only; an empty queue shows pc=0 / NOP to decode.
// Optional FETCH_QUEUE_STATS_EN adds saturating stall_cycles / bubble_cycles counters (cleared by reset only).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              bubble_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            push;
  logic            pop;

  // Handshake and head presentation; empty queue shows a canonical bubble, never stale storage.
  always_comb begin
    in_ready  = (count < CNT_FULL);
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
      out_pc    = mem_pc[head];
      out_instr = mem_instr[head];
    end
  end

  // Storage is not reset; only slots behind the occupancy count are ever shown.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_pc[tail]    <= in_pc;
      mem_instr[tail] <= in_instr;
    end
  end

  // Pointers and occupancy; flush discards any push/pop of its cycle. Full/empty comes from count only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  // Saturating stall/bubble counters; they survive flush so they span redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (out_ready && !out_valid && (bubble_cycles != 32'hFFFF_FFFF))
        bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

  // Fetch must hold a refused entry stable until it is taken (a redirect may replace it).
  property p_hold_refused;
    @(posedge clk) disable iff (reset)
      (in_valid && !in_ready && !flush) |=> (!in_valid || ($stable(in_pc) && $stable(in_instr)));
  endproperty
  a_hold_refused: assert property (p_hold_refused);

endmodule
